// File: rtl/detect_event_counter_if.sv
// Bundle between the sequence-detector side and the event counter.
//   det_in      : detector output level (master -> slave)
//   clear       : synchronous clear of count/overflow (master -> slave)
//   hold        : freeze counting, events dropped (master -> slave)
//   count       : current event count (slave -> master)
//   seg         : 7-segment pattern {dp,g,f,e,d,c,b,a}, active-high (slave -> master)
//   event_pulse : one-cycle pulse per counted event (slave -> master)
//   overflow    : sticky wrap flag (slave -> master)
interface detect_event_counter_if #(
  parameter int NBITS_SEG = 8
);
  logic                 det_in;
  logic                 clear;
  logic                 hold;
  logic [3:0]           count;
  logic [NBITS_SEG-1:0] seg;
  logic                 event_pulse;
  logic                 overflow;

  modport master (output det_in, clear, hold,
                  input  count, seg, event_pulse, overflow);
  modport slave  (input  det_in, clear, hold,
                  output count, seg, event_pulse, overflow);
endinterface

// File: rtl/detect_event_counter.sv
// Counts rising assertions of the "three consecutive 1s" detector output and
// shows the count as a hex digit on a 7-segment display, with the decimal
// point used as a sticky wrap-around flag.
//   clk_2  : system clock
//   reset  : synchronous, active-high reset
//   bus    : slave side of detect_event_counter_if (det_in/clear/hold in,
//            count/seg/event_pulse/overflow out)
// All outputs are registered; seg is decoded from the next-state count so it
// changes on the same edge as count.
module detect_event_counter #(
  parameter int CNT_MAX   = 9,  // last value before wrap, 1..15
  parameter int NBITS_SEG = 8
) (
  input  logic                  clk_2,
  input  logic                  reset,
  detect_event_counter_if.slave bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
  localparam logic [3:0] CMAX   = 4'(CNT_MAX);

  logic [0:0]           state_q, state_d;
  logic [3:0]           count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 pulse_q, pulse_d;
  logic [NBITS_SEG-1:0] seg_q, seg_d;
  logic                 new_event;
  logic [6:0]           pat;

  // A high level of any length is one event; re-arm needs a low cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.det_in)  state_d = ACTIVE;
      ACTIVE:  if (!bus.det_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign new_event = (state_q == IDLE) && bus.det_in;

  // Clear beats hold and beats a coincident event; hold drops the event
  // outright (the FSM still goes ACTIVE, so it is not replayed later).
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    pulse_d = 1'b0;
    if (bus.clear) begin
      count_d = 4'd0;
      ovf_d   = 1'b0;
    end else if (new_event && !bus.hold) begin
      pulse_d = 1'b1;
      if (count_q == CMAX) begin
        count_d = 4'd0;
        ovf_d   = 1'b1;
      end else begin
        count_d = count_q + 4'd1;
      end
    end
  end

  // {g,f,e,d,c,b,a}
  always_comb begin
    case (count_d)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
  end

  assign seg_d = NBITS_SEG'({ovf_d, pat});

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
      seg_q   <= NBITS_SEG'(8'h3F);
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.count       = count_q;
  assign bus.seg         = seg_q;
  assign bus.event_pulse = pulse_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_detect_event_counter.sv
// Drives two counters (CNT_MAX=9 and CNT_MAX=15) with one shared directed
// stimulus; a behavioural model of each is compared on every falling edge,
// and literal expectations pin key points of the scenario.
module tb_detect_event_counter;

  logic clk_2 = 1'b0;
  logic reset, det, clr, hld;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  always #5 clk_2 = ~clk_2;

  detect_event_counter_if #(.NBITS_SEG(8)) if9 ();
  detect_event_counter_if #(.NBITS_SEG(8)) if15 ();

  assign if9.det_in  = det;
  assign if9.clear   = clr;
  assign if9.hold    = hld;
  assign if15.det_in = det;
  assign if15.clear  = clr;
  assign if15.hold   = hld;

  detect_event_counter #(.CNT_MAX(9), .NBITS_SEG(8)) dut9 (
    .clk_2(clk_2), .reset(reset), .bus(if9.slave));
  detect_event_counter #(.CNT_MAX(15), .NBITS_SEG(8)) dut15 (
    .clk_2(clk_2), .reset(reset), .bus(if15.slave));

  // ---------------- model ----------------
  int m_cnt [2];
  bit m_ovf [2];
  bit m_pls [2];
  bit m_last[2];   // det_in seen on the previous edge (0 after reset)
  int cmax  [2] = '{9, 15};

  function automatic int seg_of(input int c, input bit o);
    int hex [16] = '{'h3F,'h06,'h5B,'h4F,'h66,'h6D,'h7D,'h07,
                     'h7F,'h6F,'h77,'h7C,'h39,'h5E,'h79,'h71};
    return (o ? 'h80 : 0) | hex[c];
  endfunction

  always @(posedge clk_2) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_cnt[i] <= 0; m_ovf[i] <= 1'b0; m_pls[i] <= 1'b0; m_last[i] <= 1'b0;
      end else begin
        m_last[i] <= det;
        if (clr) begin
          m_cnt[i] <= 0; m_ovf[i] <= 1'b0; m_pls[i] <= 1'b0;
        end else if (det && !m_last[i] && !hld) begin
          m_cnt[i] <= (m_cnt[i] + 1) % (cmax[i] + 1);
          if (m_cnt[i] == cmax[i]) m_ovf[i] <= 1'b1;
          m_pls[i] <= 1'b1;
        end else begin
          m_pls[i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_2) begin
    if (chk_en) begin
      chk("m9.count", int'(if9.count), m_cnt[0]);
      chk("m9.seg",   int'(if9.seg), seg_of(m_cnt[0], m_ovf[0]));
      chk("m9.pulse", int'(if9.event_pulse), int'(m_pls[0]));
      chk("m9.ovf",   int'(if9.overflow), int'(m_ovf[0]));
      chk("m15.count", int'(if15.count), m_cnt[1]);
      chk("m15.seg",   int'(if15.seg), seg_of(m_cnt[1], m_ovf[1]));
      chk("m15.pulse", int'(if15.event_pulse), int'(m_pls[1]));
      chk("m15.ovf",   int'(if15.overflow), int'(m_ovf[1]));
    end
  end

  // ---------------- stimulus ----------------
  int npulse;

  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic pulse_det();
    det = 1'b1; step();
    det = 1'b0; step();
  endtask

  initial begin
    reset = 1'b1; det = 1'b1; clr = 1'b0; hld = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    chk("rst.count", int'(if9.count), 0);
    chk("rst.seg",   int'(if9.seg), 'h3F);
    chk("rst.pulse", int'(if9.event_pulse), 0);
    chk("rst.ovf",   int'(if9.overflow), 0);

    // det_in already high on the first edge after release counts
    reset = 1'b0; step();
    chk("rel.count", int'(if9.count), 1);
    chk("rel.seg",   int'(if9.seg), 'h06);
    chk("rel.pulse", int'(if9.event_pulse), 1);
    det = 1'b0; step();

    // 5 high, 1 low, 1 high -> exactly two one-cycle pulses
    npulse = 0;
    det = 1'b1;
    for (int k = 0; k < 5; k++) begin step(); npulse += int'(if9.event_pulse); end
    det = 1'b0; step(); npulse += int'(if9.event_pulse);
    det = 1'b1; step(); npulse += int'(if9.event_pulse);
    det = 1'b0; step(); npulse += int'(if9.event_pulse);
    chk("long.pulses", npulse, 2);
    chk("long.count",  int'(if9.count), 3);

    // wrap at CNT_MAX=9
    clr = 1'b1; step(); clr = 1'b0;
    for (int k = 0; k < 10; k++) pulse_det();
    chk("wrap.count", int'(if9.count), 0);
    chk("wrap.seg",   int'(if9.seg), 'hBF);
    chk("wrap.ovf",   int'(if9.overflow), 1);
    pulse_det();
    chk("wrap11.count", int'(if9.count), 1);
    chk("wrap11.seg",   int'(if9.seg), 'h86);
    chk("wrap11.ovf",   int'(if9.overflow), 1);

    // hold during rise drops the event; no replay after hold drops
    hld = 1'b1; det = 1'b1; step();
    chk("hold.pulse", int'(if9.event_pulse), 0);
    hld = 1'b0; step();
    chk("hold.count", int'(if9.count), 1);
    chk("hold.pulse2", int'(if9.event_pulse), 0);
    det = 1'b0; step();
    det = 1'b1; step();
    chk("hold.fresh", int'(if9.count), 2);
    det = 1'b0; step();

    // clear coincident with a rise at count=4
    pulse_det(); pulse_det();
    chk("clr.pre", int'(if9.count), 4);
    clr = 1'b1; det = 1'b1; step();
    chk("clr.count", int'(if9.count), 0);
    chk("clr.ovf",   int'(if9.overflow), 0);
    chk("clr.pulse", int'(if9.event_pulse), 0);
    clr = 1'b0; step(); step();
    chk("clr.held", int'(if9.count), 0);
    det = 1'b0; step();
    det = 1'b1; step();
    chk("clr.rearm", int'(if9.count), 1);
    det = 1'b0; step();

    // clear and hold together behave as clear
    clr = 1'b1; hld = 1'b1; det = 1'b1; step();
    chk("clrhld.count", int'(if9.count), 0);
    clr = 1'b0; hld = 1'b0; det = 1'b0; step();

    // reset mid-operation with det high
    pulse_det();
    reset = 1'b1; det = 1'b1; step();
    chk("midrst.count", int'(if9.count), 0);
    det = 1'b0; step();
    reset = 1'b0; step();

    // CNT_MAX=15 wrap
    for (int k = 0; k < 15; k++) pulse_det();
    chk("m15.F.count", int'(if15.count), 15);
    chk("m15.F.seg",   int'(if15.seg), 'h71);
    pulse_det();
    chk("m15.wrap.count", int'(if15.count), 0);
    chk("m15.wrap.ovf",   int'(if15.overflow), 1);
    chk("m15.wrap.seg",   int'(if15.seg), 'hBF);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
